// File: rtl/instruction_fetch_stage.sv
// IF stage: PC, instruction memory and IF/ID register, with program-load phase,
// HDU stall enables, jump/branch redirects, debug freeze and HALT handling.
module instruction_fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  input  logic        inPC_write,
  input  logic        inIF_ID_write,
  input  logic        inJumpTake,
  input  logic [31:0] inAddress_jump,
  input  logic        inBranchTake,
  input  logic [31:0] inBranchAddr,
  input  logic        stop_debug,
  output logic [31:0] outInstruction,
  output logic [31:0] outInstructionAddress,
  output logic [31:0] outPC,
  output logic        outHalted,
  output logic        outLoading
);

  localparam int unsigned AW  = $clog2(IMEM_DEPTH);
  localparam logic [31:0] NOP = 32'd0;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_iaddr;
  logic        r_halted;
  logic        r_loading;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_iaddr_nxt;
  logic [31:0] w_fetch;
  logic [31:0] w_pc_inc;
  logic        w_unused_addr;

  logic [31:0] r_imem [IMEM_DEPTH];

  // Contents survive reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && load_en) begin
      r_imem[load_addr[AW-1:0]] <= load_data;
    end
  end

  assign w_fetch       = r_imem[r_pc[AW-1:0]];
  assign w_pc_inc      = r_pc + 32'd1;
  assign w_unused_addr = ^load_addr[31:AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_LOAD;
      r_pc      <= RESET_PC;
      r_instr   <= NOP;
      r_iaddr   <= 32'd0;
      r_halted  <= 1'b0;
      r_loading <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_iaddr   <= w_iaddr_nxt;
      r_halted  <= (w_state_nxt == S_HALT);
      r_loading <= (w_state_nxt == S_LOAD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_iaddr_nxt = r_iaddr;
    if (!stop_debug) begin
      case (r_state)
        S_LOAD: begin
          w_instr_nxt = NOP;
          w_iaddr_nxt = 32'd0;
          if (load_done) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (inBranchTake) begin
            w_pc_nxt = inBranchAddr;
          end else if (!inPC_write) begin
            w_pc_nxt = r_pc;
          end else if (inJumpTake) begin
            w_pc_nxt = inAddress_jump;
          end else begin
            w_pc_nxt = w_pc_inc;
          end

          if (inBranchTake) begin
            w_instr_nxt = NOP;
            w_iaddr_nxt = 32'd0;
          end else if (!inIF_ID_write) begin
            w_instr_nxt = r_instr;
            w_iaddr_nxt = r_iaddr;
          end else if (inJumpTake) begin
            w_instr_nxt = NOP;
            w_iaddr_nxt = 32'd0;
          end else begin
            w_instr_nxt = w_fetch;
            w_iaddr_nxt = w_pc_inc;
            // Halt only once the word really enters IF/ID; the PC parks on it.
            if (w_fetch[31:26] == HALT_OP) begin
              w_state_nxt = S_HALT;
              w_pc_nxt    = r_pc;
            end
          end
        end
        S_HALT: begin
          w_instr_nxt = NOP;
          w_iaddr_nxt = 32'd0;
          if (inBranchTake) begin
            w_pc_nxt    = inBranchAddr;
            w_state_nxt = S_RUN;
          end
        end
        default: begin
          w_state_nxt = S_LOAD;
        end
      endcase
    end
  end

  assign outInstruction        = r_instr;
  assign outInstructionAddress = r_iaddr;
  assign outPC                 = r_pc;
  assign outHalted             = r_halted;
  assign outLoading            = r_loading;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized run
// checked against a behavioural fetch-stage model.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        inPC_write;
  logic        inIF_ID_write;
  logic        inJumpTake;
  logic [31:0] inAddress_jump;
  logic        inBranchTake;
  logic [31:0] inBranchAddr;
  logic        stop_debug;
  logic [31:0] outInstruction;
  logic [31:0] outInstructionAddress;
  logic [31:0] outPC;
  logic        outHalted;
  logic        outLoading;

  int n_checks = 0;
  int n_bad    = 0;

  // Model: mode 0 = loading, 1 = running, 2 = halted
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_iaddr;
  int          m_mode;

  instruction_fetch_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .load_en               (load_en),
    .load_addr             (load_addr),
    .load_data             (load_data),
    .load_done             (load_done),
    .inPC_write            (inPC_write),
    .inIF_ID_write         (inIF_ID_write),
    .inJumpTake            (inJumpTake),
    .inAddress_jump        (inAddress_jump),
    .inBranchTake          (inBranchTake),
    .inBranchAddr          (inBranchAddr),
    .stop_debug            (stop_debug),
    .outInstruction        (outInstruction),
    .outInstructionAddress (outInstructionAddress),
    .outPC                 (outPC),
    .outHalted             (outHalted),
    .outLoading            (outLoading)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dir_word(input int i);
    if (i == 0) return 32'h2001_0005;
    if (i == 1) return 32'h2002_0003;
    if (i == 7) return 32'hFC00_0007;
    return 32'h2000_0000 + 32'(i) * 32'h0001_0001;
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    inPC_write = 1'b1; inIF_ID_write = 1'b1; inJumpTake = 1'b0; inAddress_jump = '0;
    inBranchTake = 1'b0; inBranchAddr = '0; stop_debug = 1'b0;
  endtask

  // Advance the reference one cycle from the inputs currently applied.
  task automatic model_update();
    logic [31:0] word;
    logic        fetched;
    logic [31:0] old_pc;
    word   = m_mem[m_pc[7:0]];
    old_pc = m_pc;
    if (m_mode == 0 && load_en) m_mem[load_addr[7:0]] = load_data;
    if (rst) begin
      m_mode = 0; m_pc = 32'd0; m_instr = 32'd0; m_iaddr = 32'd0;
    end else if (stop_debug) begin
      // everything frozen
    end else if (m_mode == 0) begin
      if (load_done) m_mode = 1;
    end else if (m_mode == 2) begin
      m_instr = 32'd0; m_iaddr = 32'd0;
      if (inBranchTake) begin m_pc = inBranchAddr; m_mode = 1; end
    end else begin
      fetched = !inBranchTake && inIF_ID_write && !inJumpTake;
      if (inBranchTake)     m_pc = inBranchAddr;
      else if (inPC_write)  m_pc = inJumpTake ? inAddress_jump : old_pc + 32'd1;
      if (inBranchTake || (inIF_ID_write && inJumpTake)) begin
        m_instr = 32'd0; m_iaddr = 32'd0;
      end else if (fetched) begin
        m_instr = word; m_iaddr = old_pc + 32'd1;
        if (word[31:26] == 6'b111111) begin m_mode = 2; m_pc = old_pc; end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({outPC, outInstruction, outInstructionAddress, outHalted, outLoading} !==
        {32'd0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset: pc=%h instr=%h addr=%h halt=%b load=%b, want 0/0/0/0/1",
               outPC, outInstruction, outInstructionAddress, outHalted, outLoading);
    end
  endtask

  task automatic test_load_run();
    for (int i = 0; i < 256; i++) begin
      load_en   = 1'b1;
      load_addr = 32'(i) + 32'h100 * 32'($urandom_range(0, 3));
      load_data = dir_word(i);
      tick();
    end
    load_en = 1'b0;
    n_checks++;
    if (outLoading !== 1'b1 || outPC !== 32'd0) begin
      n_bad++;
      $display("FAIL still_loading: load=%b pc=%h, want 1/0", outLoading, outPC);
    end
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    n_checks++;
    if (outLoading !== 1'b0 || outPC !== 32'd0 || outInstruction !== 32'd0) begin
      n_bad++;
      $display("FAIL load_done: load=%b pc=%h instr=%h, want 0/0/0", outLoading, outPC, outInstruction);
    end
    tick();
    n_checks++;
    if (outInstruction !== 32'h2001_0005 || outInstructionAddress !== 32'd1) begin
      n_bad++;
      $display("FAIL first_fetch: instr=%h addr=%h, want 20010005/1", outInstruction, outInstructionAddress);
    end
    tick();
    n_checks++;
    if (outInstruction !== 32'h2002_0003 || outInstructionAddress !== 32'd2 || outPC !== 32'd2) begin
      n_bad++;
      $display("FAIL second_fetch: instr=%h addr=%h pc=%h, want 20020003/2/2",
               outInstruction, outInstructionAddress, outPC);
    end
  endtask

  task automatic test_stall();
    tick();
    n_checks++;
    if (outPC !== 32'd3) begin
      n_bad++;
      $display("FAIL pc_at_3: pc=%h, want 3", outPC);
    end
    inPC_write = 1'b0; inIF_ID_write = 1'b0;
    load_en = 1'b1; load_addr = 32'd3; load_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    n_checks++;
    if (outPC !== 32'd3 || outInstruction !== 32'h2002_0002 || outInstructionAddress !== 32'd3) begin
      n_bad++;
      $display("FAIL stall_hold: pc=%h instr=%h addr=%h, want 3/20020002/3",
               outPC, outInstruction, outInstructionAddress);
    end
    tick();
    n_checks++;
    if (outInstruction !== 32'h2003_0003 || outInstructionAddress !== 32'd4 || outPC !== 32'd4) begin
      n_bad++;
      $display("FAIL stall_resume: instr=%h addr=%h pc=%h, want 20030003/4/4",
               outInstruction, outInstructionAddress, outPC);
    end
  endtask

  task automatic test_jump();
    tick();
    inJumpTake = 1'b1; inAddress_jump = 32'h40;
    tick();
    idle_inputs();
    n_checks++;
    if (outPC !== 32'h40 || outInstruction !== 32'd0 || outInstructionAddress !== 32'd0) begin
      n_bad++;
      $display("FAIL jump_redirect: pc=%h instr=%h addr=%h, want 40/0/0",
               outPC, outInstruction, outInstructionAddress);
    end
    tick();
    n_checks++;
    if (outInstruction !== 32'h2040_0040 || outInstructionAddress !== 32'h41) begin
      n_bad++;
      $display("FAIL jump_target: instr=%h addr=%h, want 20400040/41", outInstruction, outInstructionAddress);
    end
  endtask

  task automatic test_branch_priority();
    inBranchTake = 1'b1; inBranchAddr = 32'h10;
    inJumpTake = 1'b1; inAddress_jump = 32'h80;
    inPC_write = 1'b0; inIF_ID_write = 1'b0;
    tick();
    idle_inputs();
    n_checks++;
    if (outPC !== 32'h10 || outInstruction !== 32'd0 || outInstructionAddress !== 32'd0) begin
      n_bad++;
      $display("FAIL branch_wins: pc=%h instr=%h addr=%h, want 10/0/0",
               outPC, outInstruction, outInstructionAddress);
    end
    tick();
    n_checks++;
    if (outInstruction !== 32'h2010_0010 || outInstructionAddress !== 32'h11) begin
      n_bad++;
      $display("FAIL branch_target: instr=%h addr=%h, want 20100010/11", outInstruction, outInstructionAddress);
    end
  endtask

  task automatic test_halt();
    // Halt word at 7 squashed by a jump: no halt.
    inBranchTake = 1'b1; inBranchAddr = 32'd7;
    tick();
    idle_inputs();
    inJumpTake = 1'b1; inAddress_jump = 32'h20;
    tick();
    idle_inputs();
    n_checks++;
    if (outHalted !== 1'b0 || outPC !== 32'h20) begin
      n_bad++;
      $display("FAIL squashed_halt: halt=%b pc=%h, want 0/20", outHalted, outPC);
    end
    // Halt word held by a stall: no halt until it really loads.
    inBranchTake = 1'b1; inBranchAddr = 32'd7;
    tick();
    idle_inputs();
    inPC_write = 1'b0; inIF_ID_write = 1'b0;
    tick();
    idle_inputs();
    n_checks++;
    if (outHalted !== 1'b0 || outPC !== 32'd7) begin
      n_bad++;
      $display("FAIL held_halt: halt=%b pc=%h, want 0/7", outHalted, outPC);
    end
    tick();
    n_checks++;
    if (outHalted !== 1'b1 || outPC !== 32'd7 || outInstruction !== 32'hFC00_0007 ||
        outInstructionAddress !== 32'd8) begin
      n_bad++;
      $display("FAIL halt_enter: halt=%b pc=%h instr=%h addr=%h, want 1/7/fc000007/8",
               outHalted, outPC, outInstruction, outInstructionAddress);
    end
    inJumpTake = 1'b1; inAddress_jump = 32'h30;
    tick();
    idle_inputs();
    n_checks++;
    if (outHalted !== 1'b1 || outPC !== 32'd7 || outInstruction !== 32'd0) begin
      n_bad++;
      $display("FAIL halt_hold: halt=%b pc=%h instr=%h, want 1/7/0", outHalted, outPC, outInstruction);
    end
    inBranchTake = 1'b1; inBranchAddr = 32'd2;
    tick();
    idle_inputs();
    n_checks++;
    if (outHalted !== 1'b0 || outPC !== 32'd2 || outInstruction !== 32'd0) begin
      n_bad++;
      $display("FAIL halt_exit: halt=%b pc=%h instr=%h, want 0/2/0", outHalted, outPC, outInstruction);
    end
    tick();
    n_checks++;
    if (outInstruction !== 32'h2002_0002 || outInstructionAddress !== 32'd3) begin
      n_bad++;
      $display("FAIL halt_resume: instr=%h addr=%h, want 20020002/3", outInstruction, outInstructionAddress);
    end
  endtask

  task automatic test_debug_freeze();
    logic [31:0] pc0, in0, ad0;
    inBranchTake = 1'b1; inBranchAddr = 32'h20;
    tick();
    idle_inputs();
    tick();
    pc0 = outPC; in0 = outInstruction; ad0 = outInstructionAddress;
    for (int c = 0; c < 3; c++) begin
      stop_debug = 1'b1;
      load_done  = (c == 1);
      inBranchTake = (c == 2); inBranchAddr = 32'h55;
      inJumpTake = (c == 0); inAddress_jump = 32'h66;
      tick();
      n_checks++;
      if ({outPC, outInstruction, outInstructionAddress, outHalted, outLoading} !==
          {32'h21, 32'h2020_0020, 32'h21, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL debug_freeze[%0d]: pc=%h instr=%h addr=%h halt=%b load=%b, want 21/20200020/21/0/0",
                 c, outPC, outInstruction, outInstructionAddress, outHalted, outLoading);
      end
    end
    idle_inputs();
    tick();
    n_checks++;
    if (outPC !== pc0 + 32'd1 || outInstruction !== 32'h2021_0021 || outInstructionAddress !== 32'h22) begin
      n_bad++;
      $display("FAIL debug_release: pc=%h instr=%h addr=%h, want 22/20210021/22",
               outPC, outInstruction, outInstructionAddress);
    end
    if (in0 === 32'hx || ad0 === 32'hx) $display("note: unexpected X before freeze");
  endtask

  task automatic test_reset_mid();
    inJumpTake = 1'b1; inAddress_jump = 32'h99; rst = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if ({outPC, outInstruction, outInstructionAddress, outLoading, outHalted} !==
        {32'd0, 32'd0, 32'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: pc=%h instr=%h addr=%h load=%b halt=%b, want 0/0/0/1/0",
               outPC, outInstruction, outInstructionAddress, outLoading, outHalted);
    end
    stop_debug = 1'b1; load_done = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (outLoading !== 1'b1 || outPC !== 32'd0) begin
      n_bad++;
      $display("FAIL freeze_in_load: load=%b pc=%h, want 1/0", outLoading, outPC);
    end
    load_done = 1'b1;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (outLoading !== 1'b0 || outInstruction !== 32'h2001_0005 || outInstructionAddress !== 32'd1) begin
      n_bad++;
      $display("FAIL rerun_after_reset: load=%b instr=%h addr=%h, want 0/20010005/1",
               outLoading, outInstruction, outInstructionAddress);
    end
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 300));
      1:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      2:       return $urandom();
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] w;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom();
      if ($urandom_range(0, 11) == 0) w[31:26] = 6'b111111;
      else if (w[31:26] == 6'b111111) w[31:26] = 6'b001000;
      load_en = 1'b1; load_addr = 32'(i) + 32'h100 * 32'($urandom_range(0, 7)); load_data = w;
      tick();
    end
    idle_inputs();
    load_done = 1'b1;
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 399) == 0);
      stop_debug     = ($urandom_range(0, 9) == 0);
      load_en        = ($urandom_range(0, 2) == 0);
      load_addr      = $urandom();
      load_data      = $urandom_range(0, 1) ? $urandom() : {6'b111111, 26'($urandom())};
      load_done      = (m_mode == 0) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) == 0);
      inPC_write     = ($urandom_range(0, 5) != 0);
      inIF_ID_write  = ($urandom_range(0, 5) != 0);
      inJumpTake     = ($urandom_range(0, 5) == 0);
      inAddress_jump = rand_target();
      inBranchTake   = ($urandom_range(0, 11) == 0);
      inBranchAddr   = rand_target();
      tick();
      n_checks++;
      if ({outPC, outInstruction, outInstructionAddress, outHalted, outLoading} !==
          {m_pc, m_instr, m_iaddr, m_mode == 2, m_mode == 0}) begin
        n_bad++;
        $display("FAIL random[%0d]: pc=%h instr=%h addr=%h halt=%b load=%b, want %h/%h/%h/%b/%b",
                 c, outPC, outInstruction, outInstructionAddress, outHalted, outLoading,
                 m_pc, m_instr, m_iaddr, m_mode == 2, m_mode == 0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_pc = 32'd0; m_instr = 32'd0; m_iaddr = 32'd0; m_mode = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_load_run();
    test_stall();
    test_jump();
    test_branch_priority();
    test_halt();
    test_debug_freeze();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
